// File: rtl/perf_cnt_pkg.sv
// Shared constants and types for the memory-mapped performance counter bank.
package perf_cnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } perf_state_t;

    localparam int PERF_CTRL_CLR_BIT   = 0;
    localparam int PERF_CTRL_NUM_LSB   = 0;
    localparam int PERF_CTRL_WIDTH_LSB = 8;
    localparam int PERF_CTRL_FIELD_W   = 8;

    localparam int PERF_WIN_MSB = 31;
    localparam int PERF_WIN_LSB = 6;
    localparam int PERF_IDX_MSB = 5;
    localparam int PERF_IDX_LSB = 2;

endpackage

// File: rtl/perf_edge_counter.sv
// One counter channel: registers the event level, counts rising edges, wraps freely.
module perf_edge_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 event_in,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    logic                 r_prev;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_edge;

    assign w_edge = event_in & ~r_prev;
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_prev <= event_in;
            // A clear in the same cycle as an edge leaves the counter at zero.
            if (clear) begin
                r_count <= '0;
            end else if (w_edge) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_counter_reader.sv
// Bus-facing counter bank: window decode, single-outstanding access FSM, read mux and clears.
module perf_counter_reader
    import perf_cnt_pkg::*;
#(
    parameter int          NUM_CNT   = 8,
    parameter int          CNT_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] event_in,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_address,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_resp
);

    localparam int IDX_W = PERF_IDX_MSB - PERF_IDX_LSB + 1;

    perf_state_t          r_state;
    perf_state_t          w_state_next;
    logic                 r_resp;
    logic [31:0]          r_rdata;
    logic                 w_hit;
    logic                 w_accept;
    logic [IDX_W-1:0]     w_idx;
    logic [NUM_CNT-1:0]   w_clear;
    logic [CNT_WIDTH-1:0] w_count [NUM_CNT];
    logic [31:0]          w_ctrl_word;
    logic [31:0]          w_rd_data;
    logic                 w_unused_ok;

    assign w_hit       = (mem_address[PERF_WIN_MSB:PERF_WIN_LSB] == BASE_ADDR[PERF_WIN_MSB:PERF_WIN_LSB]);
    assign w_idx       = mem_address[PERF_IDX_MSB:PERF_IDX_LSB];
    assign w_unused_ok = &{1'b0, mem_wdata, mem_address[1:0]};
    assign mem_resp    = r_resp;
    assign mem_rdata   = r_rdata;

    genvar g;
    generate
        for (g = 0; g < NUM_CNT; g++) begin : g_ch
            perf_edge_counter #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .event_in(event_in[g]),
                .clear   (w_clear[g]),
                .count   (w_count[g])
            );
        end
    endgenerate

    always_comb begin
        w_ctrl_word = '0;
        w_ctrl_word[PERF_CTRL_WIDTH_LSB +: PERF_CTRL_FIELD_W] = PERF_CTRL_FIELD_W'(CNT_WIDTH);
        w_ctrl_word[PERF_CTRL_NUM_LSB   +: PERF_CTRL_FIELD_W] = PERF_CTRL_FIELD_W'(NUM_CNT);
    end

    // A simultaneous read and write is treated as a write, so read data stays zero.
    always_comb begin
        w_rd_data = '0;
        if (!mem_write) begin
            if (w_idx == IDX_W'(NUM_CNT)) begin
                w_rd_data = w_ctrl_word;
            end
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    w_rd_data[CNT_WIDTH-1:0] = w_count[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            w_clear[i] = w_accept && mem_write &&
                         ((w_idx == IDX_W'(i)) ||
                          ((w_idx == IDX_W'(NUM_CNT)) && mem_wdata[PERF_CTRL_CLR_BIT]));
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit && (mem_read || mem_write)) begin
                    w_accept     = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_resp  <= w_accept;
            if (w_accept) begin
                r_rdata <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed and randomized checks of the counter bank against a count-per-channel model.
module tb_perf_counter_reader;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  event_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] rdata16, rdata4;
    logic        resp16, resp4;

    int total = 0;
    int bad   = 0;

    int unsigned m_cnt [8];
    logic [7:0]  m_prev;

    always #5 clk = ~clk;

    perf_counter_reader #(.NUM_CNT(8), .CNT_WIDTH(16), .BASE_ADDR(BASE)) u_dut16 (
        .clk(clk), .rst(rst), .event_in(event_in), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(rdata16), .mem_resp(resp16)
    );

    perf_counter_reader #(.NUM_CNT(8), .CNT_WIDTH(4), .BASE_ADDR(BASE)) u_dut4 (
        .clk(clk), .rst(rst), .event_in(event_in), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(rdata4), .mem_resp(resp4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; the model applies the same edge with the inputs now driven.
    task automatic tick(input logic [7:0] clr, input bit in_rst);
        for (int i = 0; i < 8; i++) begin
            if (in_rst || clr[i]) m_cnt[i] = 0;
            else if (event_in[i] && !m_prev[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        m_prev = in_rst ? 8'h00 : event_in;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wd, input string tag);
        bit          hit;
        int          idx;
        logic [31:0] exp16, exp4;
        logic [7:0]  clr;
        hit   = (addr[31:6] == BASE[31:6]);
        idx   = int'(addr[5:2]);
        exp16 = 32'h0;
        exp4  = 32'h0;
        clr   = 8'h00;
        if (!wr) begin
            if (idx < 8) begin
                exp16 = m_cnt[idx] % 65536;
                exp4  = m_cnt[idx] % 16;
            end else if (idx == 8) begin
                exp16 = 32'h0000_1008;
                exp4  = 32'h0000_0408;
            end
        end else if (hit) begin
            if (idx < 8) clr = 8'(1 << idx);
            else if (idx == 8 && wd[0]) clr = 8'hFF;
        end
        mem_address = addr;
        mem_read    = rd;
        mem_write   = wr;
        mem_wdata   = wd;
        chk({tag, "_resp_pre"}, {31'b0, resp16}, 32'd0);
        tick(clr, 1'b0);
        chk({tag, "_resp16"}, {31'b0, resp16}, {31'b0, hit});
        chk({tag, "_resp4"},  {31'b0, resp4},  {31'b0, hit});
        if (hit) begin
            chk({tag, "_rdata16"}, rdata16, exp16);
            chk({tag, "_rdata4"},  rdata4,  exp4);
        end
        tick(8'h00, 1'b0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk({tag, "_resp_post"}, {31'b0, resp16}, 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            access(BASE + 32'(i * 4), 1'b1, 1'b0, 32'h0, $sformatf("%s_c%0d", tag, i));
        end
    endtask

    initial begin
        int          seen;
        int          k;
        logic [31:0] a;
        rst = 1'b1; event_in = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0;
        m_prev = '0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);
        chk("reset_resp",  {31'b0, resp16}, 32'd0);
        chk("reset_rdata", rdata16, 32'd0);
        rst = 1'b0;

        for (int p = 0; p < 3; p++) begin
            event_in = 8'h08; tick(8'h00, 1'b0);
            event_in = 8'h00; tick(8'h00, 1'b0);
        end
        access(BASE + 32'h0C, 1'b1, 1'b0, 32'h0, "basic_c3");
        read_all("basic");

        event_in[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick(8'h00, 1'b0);
        for (int c = 0; c < 8; c++) begin
            event_in[0] = ~event_in[0];
            tick(8'h00, 1'b0);
        end
        event_in[0] = 1'b0;
        tick(8'h00, 1'b0);
        access(BASE, 1'b1, 1'b0, 32'h0, "level_c0");
        chk("level_c0_const", rdata16, 32'd5);

        event_in = 8'h02; tick(8'h00, 1'b0);
        event_in = 8'h00; tick(8'h00, 1'b0);
        event_in = 8'h02;
        access(BASE + 32'h04, 1'b0, 1'b1, 32'h0, "coll_wr");
        event_in = 8'h00; tick(8'h00, 1'b0);
        access(BASE + 32'h04, 1'b1, 1'b0, 32'h0, "coll_rd0");
        event_in = 8'h02; tick(8'h00, 1'b0);
        event_in = 8'h00; tick(8'h00, 1'b0);
        access(BASE + 32'h04, 1'b1, 1'b0, 32'h0, "coll_rd1");

        for (int p = 0; p < 17; p++) begin
            event_in = 8'h04; tick(8'h00, 1'b0);
            event_in = 8'h00; tick(8'h00, 1'b0);
        end
        access(BASE + 32'h08, 1'b1, 1'b0, 32'h0, "wrap_c2");
        chk("wrap_c2_const4", rdata4, 32'd1);

        access(BASE + 32'h20, 1'b1, 1'b0, 32'h0, "ctrl_rd");
        access(BASE + 32'h20, 1'b0, 1'b1, 32'h0, "ctrl_wr0");
        read_all("noclr");
        access(BASE + 32'h20, 1'b0, 1'b1, 32'h1, "ctrl_wr1");
        read_all("clrall");
        access(BASE + 32'h30, 1'b1, 1'b0, 32'h0, "oor_rd");
        access(BASE + 32'h14, 1'b1, 1'b1, 32'h0, "rdwr");

        mem_address = 32'h0000_0100; mem_read = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick(8'h00, 1'b0);
            if (resp16 || resp4) seen++;
        end
        mem_read = 1'b0;
        chk("miss_no_resp", 32'(seen), 32'd0);

        for (int it = 0; it < 300; it++) begin
            event_in = 8'($urandom);
            tick(8'h00, 1'b0);
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(1, 3);
                a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                access(a, k[0], k[1], $urandom, $sformatf("rnd%0d", it));
            end
        end
        event_in = '0;
        tick(8'h00, 1'b0);
        read_all("rnd_final");

        event_in = 8'hA5; tick(8'h00, 1'b0);
        event_in = 8'h00; tick(8'h00, 1'b0);
        mem_address = BASE + 32'h0C; mem_read = 1'b1;
        tick(8'h00, 1'b0);
        chk("rstresp_resp_on", {31'b0, resp16}, 32'd1);
        rst = 1'b1; mem_read = 1'b0;
        tick(8'h00, 1'b1);
        chk("rstresp_resp16_off", {31'b0, resp16}, 32'd0);
        chk("rstresp_resp4_off",  {31'b0, resp4},  32'd0);
        rst = 1'b0;
        read_all("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
